// File: rtl/div_issue_ctrl.sv
// Issue/result sequencer around a combinational 32-bit unsigned divider:
// sign stripping, multicycle settle window, sign/special-case fix-up, result hold.
module div_issue_ctrl #(
   parameter int WAIT_CYCLES = 4,
   parameter int TAG_W       = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [31:0]      in_rs1,
   input  logic [31:0]      in_rs2,
   input  logic [TAG_W-1:0] in_tag,
   output logic [31:0]      div_dividend,
   output logic [31:0]      div_divisor,
   input  logic [31:0]      div_quotient,
   input  logic [31:0]      div_remainder,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; the producer keeps valid and payload stable until then.

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t      state;
   logic [3:0]  cnt;
   logic        rem_sel;
   logic        neg_q;
   logic        neg_r;

   logic        is_signed;
   logic [31:0] mag_rs1;
   logic [31:0] mag_rs2;
   logic        div_zero;
   logic        overflow;
   logic [31:0] special_res;
   logic [31:0] fix_q;
   logic [31:0] fix_r;
   logic        accept;

   // op[0]=1 marks the unsigned flavours, op[1]=1 selects the remainder.
   always_comb begin
      is_signed   = ~in_op[0];
      mag_rs1     = (is_signed & in_rs1[31]) ? (~in_rs1 + 32'd1) : in_rs1;
      mag_rs2     = (is_signed & in_rs2[31]) ? (~in_rs2 + 32'd1) : in_rs2;
      div_zero    = (in_rs2 == 32'd0);
      overflow    = is_signed & (in_rs1 == 32'h8000_0000) & (in_rs2 == 32'hFFFF_FFFF);
      special_res = 32'd0;
      if (div_zero)
         special_res = in_op[1] ? in_rs1 : 32'hFFFF_FFFF;
      else if (overflow)
         special_res = in_op[1] ? 32'd0 : 32'h8000_0000;
      fix_q  = neg_q ? (~div_quotient + 32'd1) : div_quotient;
      fix_r  = neg_r ? (~div_remainder + 32'd1) : div_remainder;
      accept = in_valid & in_ready;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         cnt          <= 4'd0;
         rem_sel      <= 1'b0;
         neg_q        <= 1'b0;
         neg_r        <= 1'b0;
         in_ready     <= 1'b1;
         out_valid    <= 1'b0;
         busy         <= 1'b0;
         out_result   <= 32'd0;
         out_tag      <= '0;
         div_dividend <= 32'd0;
         div_divisor  <= 32'd0;
      end else if (flush) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  rem_sel      <= in_op[1];
                  neg_q        <= is_signed & (in_rs1[31] ^ in_rs2[31]);
                  neg_r        <= is_signed & in_rs1[31];
                  out_tag      <= in_tag;
                  div_dividend <= mag_rs1;
                  div_divisor  <= mag_rs2;
                  in_ready     <= 1'b0;
                  busy         <= 1'b1;
                  if (div_zero | overflow) begin
                     out_result <= special_res;
                     out_valid  <= 1'b1;
                     state      <= ST_DONE;
                  end else begin
                     cnt   <= CNT_LOAD;
                     state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt == 4'd0) begin
                  out_result <= rem_sel ? fix_r : fix_q;
                  out_valid  <= 1'b1;
                  state      <= ST_DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_DONE: begin
               // in_ready only rises after the handoff edge, so no same-cycle re-accept.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state     <= ST_IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl: signed/unsigned results, special cases,
// latency, backpressure, flush and asynchronous reset.
module tb_div_issue_ctrl;

   localparam int TAG_W = 5;
   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   logic             clk;
   logic             rst;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic [31:0]      in_rs1;
   logic [31:0]      in_rs2;
   logic [TAG_W-1:0] in_tag;
   logic [31:0]      div_dividend;
   logic [31:0]      div_divisor;
   logic [31:0]      div_quotient;
   logic [31:0]      div_remainder;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_result;
   logic [TAG_W-1:0] out_tag;
   logic             busy;

   int n_checks = 0;
   int n_bad    = 0;
   logic [31:0] exp_q[$];

   div_issue_ctrl #(.WAIT_CYCLES(4), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
      .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_quotient(div_quotient), .div_remainder(div_remainder),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag), .busy(busy)
   );

   // Combinational unsigned divider the block drives.
   assign div_quotient  = (div_divisor == 32'd0) ? 32'hFFFF_FFFF : div_dividend / div_divisor;
   assign div_remainder = (div_divisor == 32'd0) ? div_dividend  : div_dividend % div_divisor;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Presents a request at a negedge and returns just after its accept edge.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag);
      int waited;
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_tag = tag;
      waited = 0;
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check_val("accept_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
   endtask

   // Called at the first negedge after accept; waits for the result, checks it, hands it off.
   task automatic collect(input string name, input int exp_lat, input logic [TAG_W-1:0] exp_tag);
      int lat;
      logic [31:0] exp_res;
      lat = 1;
      while (!out_valid && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      exp_res = exp_q.pop_front();
      check_val({name, "_valid"}, 32'(out_valid), 32'd1);
      check_val({name, "_lat"}, 32'(lat), 32'(exp_lat));
      check_val({name, "_res"}, out_result, exp_res);
      check_val({name, "_tag"}, 32'(out_tag), 32'(exp_tag));
      out_ready = 1'b1;
      check_val({name, "_handoff_ready"}, 32'(in_ready), 32'd0);
      @(negedge clk);
      out_ready = 1'b0;
      check_val({name, "_after_valid"}, 32'(out_valid), 32'd0);
      check_val({name, "_after_ready"}, 32'(in_ready), 32'd1);
   endtask

   task automatic run_req(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [TAG_W-1:0] tag,
                          input logic [31:0] exp, input int exp_lat,
                          input logic [31:0] exp_dd, input logic [31:0] exp_dv);
      exp_q.push_back(exp);
      issue(op, a, b, tag);
      @(negedge clk);
      in_valid = 1'b0;
      if (exp_lat > 1) begin
         check_val({name, "_dividend"}, div_dividend, exp_dd);
         check_val({name, "_divisor"}, div_divisor, exp_dv);
         check_val({name, "_busy"}, 32'(busy), 32'd1);
      end
      collect(name, exp_lat, tag);
   endtask

   task automatic expect_silence(input string name);
      logic seen;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check_val(name, 32'(seen), 32'd0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00;
      in_rs1 = 32'd0; in_rs2 = 32'd0; in_tag = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_in_ready", 32'(in_ready), 32'd1);
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_out_result", out_result, 32'd0);
      check_val("rst_div_dividend", div_dividend, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Normal path: latency 5 with WAIT_CYCLES=4.
      run_req("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 5, 32'd100, 32'd7);
      run_req("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd4, 32'd2, 5, 32'd100, 32'd7);
      run_req("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 5, 32'd7, 32'd2);
      run_req("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 5, 32'd7, 32'd2);
      run_req("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd7, 32'd1, 5, 32'd7, 32'd2);
      run_req("divu_big_2", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'h7FFF_FFFC, 5,
              32'hFFFF_FFF9, 32'd2);

      // Special cases: latency 1.
      run_req("div_by_0", OP_DIV, 32'h1234_5678, 32'd0, 5'd9, 32'hFFFF_FFFF, 1, 32'd0, 32'd0);
      run_req("remu_by_0", OP_REMU, 32'h1234_5678, 32'd0, 5'd10, 32'h1234_5678, 1, 32'd0, 32'd0);
      run_req("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1, 32'd0, 32'd0);
      run_req("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 1, 32'd0, 32'd0);
      run_req("divu_ovf_ops", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, 5,
              32'h8000_0000, 32'hFFFF_FFFF);

      // Backpressure: result held for 6 cycles while a new request waits.
      exp_q.push_back(32'd14);
      issue(OP_DIVU, 32'd100, 32'd7, 5'd14);
      @(negedge clk);
      in_valid = 1'b0;
      while (!out_valid && n_bad < 1000) begin
         @(negedge clk);
         if (busy == 1'b0) break;
      end
      in_valid = 1'b1; in_op = OP_REMU; in_rs1 = 32'd100; in_rs2 = 32'd7; in_tag = 5'd15;
      repeat (6) begin
         @(negedge clk);
         check_val("bp_valid", 32'(out_valid), 32'd1);
         check_val("bp_result", out_result, 32'd14);
         check_val("bp_tag", 32'(out_tag), 32'd14);
         check_val("bp_in_ready", 32'(in_ready), 32'd0);
      end
      void'(exp_q.pop_front());
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_val("bp_reaccept_ready", 32'(in_ready), 32'd1);
      exp_q.push_back(32'd2);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check_val("bp_second_busy", 32'(busy), 32'd1);
      collect("bp_second", 5, 5'd15);

      // Flush in the second WAIT cycle.
      issue(OP_DIVU, 32'd50, 32'd5, 5'd16);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check_val("flush_busy", 32'(busy), 32'd0);
      check_val("flush_in_ready", 32'(in_ready), 32'd1);
      check_val("flush_out_valid", 32'(out_valid), 32'd0);
      expect_silence("flush_no_result");

      // Asynchronous reset mid-WAIT.
      issue(OP_DIVU, 32'd50, 32'd5, 5'd17);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_val("arst_in_ready", 32'(in_ready), 32'd1);
      check_val("arst_out_valid", 32'(out_valid), 32'd0);
      check_val("arst_busy", 32'(busy), 32'd0);
      check_val("arst_out_result", out_result, 32'd0);
      check_val("arst_out_tag", 32'(out_tag), 32'd0);
      check_val("arst_div_dividend", div_dividend, 32'd0);
      check_val("arst_div_divisor", div_divisor, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      expect_silence("arst_no_result");

      run_req("divu_9_3", OP_DIVU, 32'd9, 32'd3, 5'd18, 32'd3, 5, 32'd9, 32'd3);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

   initial begin
      #200000;
      n_bad++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $fatal(1, "watchdog expired");
   end

endmodule
